// File: rtl/controlador_volcado_memoria.sv
// Arbitrates the single-port data memory between the CPU MEM stage and the debug dump engine.
// The dump engine streams LEN consecutive words from BASE over valid/ready; the CPU has priority, bounded by a starvation counter.
module controlador_volcado_memoria #(
  parameter int NBITS      = 32,
  parameter int CELDAS     = 10,
  parameter int NB_LEN     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NBITS-1:0]  i_cpu_addr,
  input  logic [NBITS-1:0]  i_cpu_wdata,
  input  logic              i_cpu_mem_read,
  input  logic              i_cpu_mem_write,
  output logic              o_cpu_stall,
  input  logic              i_dump_start,
  input  logic [NBITS-1:0]  i_dump_base,
  input  logic [NB_LEN-1:0] i_dump_len,
  output logic [NBITS-1:0]  o_dump_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic              o_dump_busy,
  output logic              o_dump_done,
  output logic [NBITS-1:0]  o_mem_addr,
  output logic [NBITS-1:0]  o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [NBITS-1:0]  i_mem_rdata
);

  localparam int NB_STARVE = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAPT  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_r;
  logic [NBITS-1:0]     dump_addr_r;
  logic [NB_LEN-1:0]    remaining_r;
  logic [NB_STARVE-1:0] starve_cnt_r;
  logic                 cpu_req_s;
  logic                 starved_s;
  logic                 grant_s;
  logic                 forced_s;

  function automatic logic [NBITS-1:0] wrap_addr(input logic [NBITS-1:0] addr);
    return addr % NBITS'(CELDAS);
  endfunction

  function automatic logic [NBITS-1:0] next_addr(input logic [NBITS-1:0] addr);
    logic [NBITS-1:0] inc;
    inc = addr + NBITS'(1'b1);
    return (inc == NBITS'(CELDAS)) ? {NBITS{1'b0}} : inc;
  endfunction

  // Decide who owns the memory port this cycle
  always_comb begin
    cpu_req_s = i_cpu_mem_read | i_cpu_mem_write;
    starved_s = (starve_cnt_r == NB_STARVE'(STARVE_MAX));
    grant_s   = 1'b0;
    forced_s  = 1'b0;
    if (state_r == ISSUE) begin
      forced_s = cpu_req_s & starved_s;
      grant_s  = ~cpu_req_s | starved_s;
    end else begin
      forced_s = 1'b0;
      grant_s  = 1'b0;
    end
  end

  // Memory port mux; a granted dump read never carries a CPU write
  always_comb begin
    o_mem_wdata = i_cpu_wdata;
    o_mem_addr  = i_cpu_addr;
    o_mem_read  = i_cpu_mem_read;
    o_mem_write = i_cpu_mem_write;
    if (grant_s) begin
      o_mem_addr  = dump_addr_r;
      o_mem_read  = 1'b1;
      o_mem_write = 1'b0;
    end else begin
      o_mem_addr  = i_cpu_addr;
      o_mem_read  = i_cpu_mem_read;
      o_mem_write = i_cpu_mem_write;
    end
  end

  assign o_cpu_stall = forced_s;
  assign o_dump_busy = (state_r != IDLE);

  // Dump sequencer with registered stream outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r      <= IDLE;
      dump_addr_r  <= '0;
      remaining_r  <= '0;
      starve_cnt_r <= '0;
      o_dump_data  <= '0;
      o_dump_valid <= 1'b0;
      o_dump_done  <= 1'b0;
    end else begin
      o_dump_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_dump_start) begin
            dump_addr_r  <= wrap_addr(i_dump_base);
            remaining_r  <= i_dump_len;
            starve_cnt_r <= '0;
            state_r      <= (i_dump_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (grant_s) begin
            starve_cnt_r <= '0;
            state_r      <= CAPT;
          end else if (!starved_s) begin
            starve_cnt_r <= starve_cnt_r + NB_STARVE'(1'b1);
          end
        end
        CAPT: begin
          o_dump_data  <= i_mem_rdata;
          o_dump_valid <= 1'b1;
          state_r      <= HOLD;
        end
        HOLD: begin
          if (o_dump_valid && i_dump_ready) begin
            o_dump_valid <= 1'b0;
            dump_addr_r  <= next_addr(dump_addr_r);
            remaining_r  <= remaining_r - NB_LEN'(1'b1);
            state_r      <= (remaining_r == NB_LEN'(1'b1)) ? DONE : ISSUE;
          end
        end
        DONE: begin
          o_dump_done <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          o_dump_valid <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_volcado_memoria.sv
// Directed bench for controlador_volcado_memoria with a behavioural data memory
// and a scoreboard of expected dump words.
module tb_controlador_volcado_memoria;

  localparam int NBITS      = 32;
  localparam int CELDAS     = 10;
  localparam int NB_LEN     = 8;
  localparam int STARVE_MAX = 4;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic [NBITS-1:0]  i_cpu_addr;
  logic [NBITS-1:0]  i_cpu_wdata;
  logic              i_cpu_mem_read;
  logic              i_cpu_mem_write;
  logic              o_cpu_stall;
  logic              i_dump_start;
  logic [NBITS-1:0]  i_dump_base;
  logic [NB_LEN-1:0] i_dump_len;
  logic [NBITS-1:0]  o_dump_data;
  logic              o_dump_valid;
  logic              i_dump_ready;
  logic              o_dump_busy;
  logic              o_dump_done;
  logic [NBITS-1:0]  o_mem_addr;
  logic [NBITS-1:0]  o_mem_wdata;
  logic              o_mem_read;
  logic              o_mem_write;
  logic [NBITS-1:0]  i_mem_rdata;

  logic [NBITS-1:0] mem [CELDAS] = '{32'd1, 32'd15, 32'd3, 32'd103, 32'd104,
                                     32'd105, 32'd106, 32'd107, 32'd9, 32'd10};

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int c0;
  int h0;
  int d0;
  int g0;
  int v0;
  logic [NBITS-1:0] sb [$];
  int hs_cyc [$];
  int done_cyc [$];
  logic [NBITS-1:0] grant_addr [$];
  int valid_cnt = 0;

  controlador_volcado_memoria #(
    .NBITS(NBITS), .CELDAS(CELDAS), .NB_LEN(NB_LEN), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .i_cpu_mem_read(i_cpu_mem_read), .i_cpu_mem_write(i_cpu_mem_write),
    .o_cpu_stall(o_cpu_stall),
    .i_dump_start(i_dump_start), .i_dump_base(i_dump_base), .i_dump_len(i_dump_len),
    .o_dump_data(o_dump_data), .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
    .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Memory model: registered read on posedge, write on negedge
  always @(posedge i_clk) if (o_mem_read) i_mem_rdata <= mem[o_mem_addr % CELDAS];
  always @(negedge i_clk) if (o_mem_write) mem[o_mem_addr % CELDAS] <= o_mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe mid-cycle at negedge, then advance to just after posedge
  task automatic step();
    logic [NBITS-1:0] exp_word;
    @(negedge i_clk);
    if (o_dump_valid && i_dump_ready) begin
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("sb_nonempty_at_word", 32'(sb.size()), 32'd1);
      end else begin
        exp_word = sb.pop_front();
        chk("dump_word", o_dump_data, exp_word);
      end
    end
    if (o_dump_done) done_cyc.push_back(cyc);
    if (o_dump_valid) valid_cnt++;
    if (o_mem_read && !i_cpu_mem_read) grant_addr.push_back(o_mem_addr);
    @(posedge i_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_dump(input logic [NBITS-1:0] base, input logic [NB_LEN-1:0] len);
    i_dump_start = 1'b1;
    i_dump_base  = base;
    i_dump_len   = len;
    c0 = cyc;
    h0 = hs_cyc.size();
    d0 = done_cyc.size();
    g0 = grant_addr.size();
    v0 = valid_cnt;
    step();
    i_dump_start = 1'b0;
  endtask

  initial begin
    i_reset_n       = 1'b0;
    i_cpu_addr      = 32'd0;
    i_cpu_wdata     = 32'd0;
    i_cpu_mem_read  = 1'b0;
    i_cpu_mem_write = 1'b0;
    i_dump_start    = 1'b0;
    i_dump_base     = 32'd0;
    i_dump_len      = 8'd0;
    i_dump_ready    = 1'b1;
    run(2);
    #1;
    chk("rst_busy", 32'(o_dump_busy), 32'd0);
    chk("rst_valid", 32'(o_dump_valid), 32'd0);
    chk("rst_done", 32'(o_dump_done), 32'd0);
    chk("rst_data", o_dump_data, 32'd0);
    chk("rst_stall", 32'(o_cpu_stall), 32'd0);
    i_reset_n = 1'b1;
    run(1);

    // base=0, len=3, no CPU traffic: three words 3 cycles apart, one done pulse
    sb.push_back(32'd1); sb.push_back(32'd15); sb.push_back(32'd3);
    start_dump(32'd0, 8'd3);
    #1;
    chk("t2_grant_read", 32'(o_mem_read), 32'd1);
    chk("t2_grant_addr", o_mem_addr, 32'd0);
    chk("t2_busy", 32'(o_dump_busy), 32'd1);
    run(13);
    chk("t2_words", 32'(hs_cyc.size() - h0), 32'd3);
    if (hs_cyc.size() - h0 == 3) begin
      chk("t2_lat0", 32'(hs_cyc[h0]), 32'(c0 + 3));
      chk("t2_lat1", 32'(hs_cyc[h0 + 1]), 32'(c0 + 6));
      chk("t2_lat2", 32'(hs_cyc[h0 + 2]), 32'(c0 + 9));
    end
    chk("t2_done_cnt", 32'(done_cyc.size() - d0), 32'd1);
    if (done_cyc.size() - d0 == 1) chk("t2_done_cyc", 32'(done_cyc[d0]), 32'(c0 + 11));

    // base=8, len=4: addresses wrap 8,9,0,1
    sb.push_back(32'd9); sb.push_back(32'd10); sb.push_back(32'd1); sb.push_back(32'd15);
    start_dump(32'd8, 8'd4);
    run(16);
    chk("t3_grants", 32'(grant_addr.size() - g0), 32'd4);
    if (grant_addr.size() - g0 == 4) begin
      chk("t3_addr0", grant_addr[g0], 32'd8);
      chk("t3_addr1", grant_addr[g0 + 1], 32'd9);
      chk("t3_addr2", grant_addr[g0 + 2], 32'd0);
      chk("t3_addr3", grant_addr[g0 + 3], 32'd1);
    end
    chk("t3_done_cnt", 32'(done_cyc.size() - d0), 32'd1);

    // base beyond the memory: 12 reads word 2
    sb.push_back(32'd3);
    start_dump(32'd12, 8'd1);
    run(6);
    chk("t3b_grants", 32'(grant_addr.size() - g0), 32'd1);
    if (grant_addr.size() - g0 == 1) chk("t3b_addr", grant_addr[g0], 32'd2);

    // CPU reads continuously: STARVE_MAX pass-through cycles, then one forced stall
    i_cpu_mem_read = 1'b1;
    i_cpu_addr     = 32'd5;
    sb.push_back(32'd107);
    start_dump(32'd7, 8'd1);
    for (int i = 0; i < STARVE_MAX; i++) begin
      #1;
      chk("t4_pass_addr", o_mem_addr, 32'd5);
      chk("t4_pass_stall", 32'(o_cpu_stall), 32'd0);
      step();
    end
    #1;
    chk("t4_forced_stall", 32'(o_cpu_stall), 32'd1);
    chk("t4_forced_addr", o_mem_addr, 32'd7);
    chk("t4_forced_read", 32'(o_mem_read), 32'd1);
    step();
    #1;
    chk("t4_capt_stall", 32'(o_cpu_stall), 32'd0);
    chk("t4_capt_addr", o_mem_addr, 32'd5);
    step();
    i_cpu_mem_read = 1'b0;
    run(3);
    chk("t4_words", 32'(hs_cyc.size() - h0), 32'd1);
    if (hs_cyc.size() - h0 == 1) chk("t4_lat", 32'(hs_cyc[h0]), 32'(c0 + 7));

    // CPU writes continuously to the dumped word: forced cycle blocks the write
    i_cpu_mem_write = 1'b1;
    i_cpu_addr      = 32'd3;
    i_cpu_wdata     = 32'hDEAD;
    #1;
    chk("t4b_wr_pass", 32'(o_mem_write), 32'd1);
    chk("t4b_wdata", o_mem_wdata, 32'hDEAD);
    sb.push_back(32'hDEAD);
    start_dump(32'd3, 8'd1);
    run(STARVE_MAX);
    #1;
    chk("t4b_forced_stall", 32'(o_cpu_stall), 32'd1);
    chk("t4b_forced_nowr", 32'(o_mem_write), 32'd0);
    step();
    i_cpu_mem_write = 1'b0;
    run(5);
    chk("t4b_done_cnt", 32'(done_cyc.size() - d0), 32'd1);

    // ready low in HOLD: data stable, CPU passes through, second start ignored
    i_dump_ready = 1'b0;
    sb.push_back(32'd15); sb.push_back(32'd3);
    start_dump(32'd1, 8'd2);
    run(2);
    i_cpu_mem_read = 1'b1;
    i_cpu_addr     = 32'd6;
    for (int i = 0; i < 5; i++) begin
      i_dump_start = (i == 2);
      i_dump_base  = 32'd9;
      i_dump_len   = 8'd1;
      #1;
      chk("t5_valid_held", 32'(o_dump_valid), 32'd1);
      chk("t5_data_stable", o_dump_data, 32'd15);
      chk("t5_cpu_addr", o_mem_addr, 32'd6);
      chk("t5_cpu_stall", 32'(o_cpu_stall), 32'd0);
      step();
    end
    i_dump_start   = 1'b0;
    i_cpu_mem_read = 1'b0;
    i_dump_ready   = 1'b1;
    run(8);
    chk("t5_words", 32'(hs_cyc.size() - h0), 32'd2);
    if (hs_cyc.size() - h0 == 2) begin
      chk("t5_hs0", 32'(hs_cyc[h0]), 32'(c0 + 8));
      chk("t5_hs1", 32'(hs_cyc[h0 + 1]), 32'(c0 + 11));
    end
    chk("t5_done_cnt", 32'(done_cyc.size() - d0), 32'd1);

    // len=0: done two cycles after start, no valid
    start_dump(32'd4, 8'd0);
    run(4);
    chk("t6_done_cnt", 32'(done_cyc.size() - d0), 32'd1);
    if (done_cyc.size() - d0 == 1) chk("t6_done_cyc", 32'(done_cyc[d0]), 32'(c0 + 2));
    chk("t6_no_valid", 32'(valid_cnt - v0), 32'd0);

    // reset during HOLD abandons the dump
    i_dump_ready = 1'b0;
    sb.push_back(32'd1); sb.push_back(32'd15); sb.push_back(32'd3);
    start_dump(32'd0, 8'd3);
    run(2);
    #1;
    chk("t1_in_hold", 32'(o_dump_valid), 32'd1);
    i_reset_n = 1'b0;
    step();
    #1;
    chk("t1_rst_valid", 32'(o_dump_valid), 32'd0);
    chk("t1_rst_busy", 32'(o_dump_busy), 32'd0);
    chk("t1_rst_done", 32'(o_dump_done), 32'd0);
    i_reset_n = 1'b1;
    sb.delete();
    i_dump_ready = 1'b1;
    run(6);
    chk("t1_no_done", 32'(done_cyc.size() - d0), 32'd0);
    chk("t1_no_words", 32'(hs_cyc.size() - h0), 32'd0);
    chk("t1_idle", 32'(o_dump_busy), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
